// File: rtl/ram_sp_param.sv
`default_nettype none
// ============================================================================
//  Module   : ram_sp_param
//  Purpose  : Parametrised single-port synchronous RAM with per-byte write
//             enables, registered read with valid strobe, selectable
//             read-during-write behaviour and a hardware clear sequencer that
//             presets every word to CLEAR_VAL after reset or on request.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W    word width in bits (multiple of 8)
//    ADDR_W    address width, DEPTH = 2**ADDR_W
//    READ_MODE 0 = read-first, 1 = write-first on same-address read+write
//    CLEAR_VAL value written to every word by the clear sequencer
//  Ports
//    clk       clock, all state changes on the rising edge
//    rst_n     asynchronous active-low reset
//    clr_req   request a full-array clear (honoured only when not busy)
//    wr_en     write strobe
//    be        byte-lane enables, lane i covers din[8i+7:8i]
//    rd_en     read strobe
//    addr      word address for read and/or write
//    din       write data
//    dout      registered read data
//    rd_valid  one-cycle pulse: dout was updated by a read on this edge
//    busy      clear sequencer active, accesses are ignored
// ============================================================================
module ram_sp_param #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 4,
    parameter int                 READ_MODE = 0,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    input  logic                  wr_en,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int                c_depth    = 2 ** ADDR_W;
    localparam int                c_lanes    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_ptr_last = '1;
    localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_ptr;
    logic [DATA_W-1:0]    r_dout;
    logic                 r_rd_valid;
    logic [DATA_W-1:0]    r_mem [c_depth];

    logic [DATA_W-1:0]    w_old;
    logic [DATA_W-1:0]    w_merged;
    logic [DATA_W-1:0]    w_rd_data;
    logic                 w_idle;

    assign w_idle = (r_state == S_IDLE);
    assign w_old  = r_mem[addr];

    // Merged word: enabled lanes come from din, the rest keep the stored
    // value. With be all-zero this equals the old word, so a write with no
    // lanes enabled rewrites identical data and is effectively a no-op.
    for (genvar gi = 0; gi < c_lanes; gi++) begin : g_lane
        assign w_merged[8*gi +: 8] = be[gi] ? din[8*gi +: 8] : w_old[8*gi +: 8];
    end

    // Read-during-write: write-first forwards the merged word only when a
    // write is actually presented; otherwise both modes return stored data.
    assign w_rd_data = ((READ_MODE != 0) && wr_en) ? w_merged : w_old;

    // ------------------------------------------------------------------------
    // Control FSM and registered read path
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_ptr      <= '0;
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    // Accesses are ignored; dout holds. The pointer wraps
                    // naturally back to zero on the final word.
                    r_rd_valid <= 1'b0;
                    r_ptr      <= r_ptr + c_ptr_one;
                    if (r_ptr == c_ptr_last) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    r_rd_valid <= rd_en;
                    if (rd_en) begin
                        r_dout <= w_rd_data;
                    end
                    // The access on this edge is still performed; the clear
                    // begins on the following edge.
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                default: begin
                    r_state    <= S_CLEAR;
                    r_ptr      <= '0;
                    r_rd_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Storage array. Not reset; the clear sequencer initialises it. Writes
    // are suppressed while reset is held so the array is untouched by reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!w_idle) begin
                r_mem[r_ptr] <= CLEAR_VAL;
            end else if (wr_en) begin
                r_mem[addr] <= w_merged;
            end
        end
    end

    assign dout     = r_dout;
    assign rd_valid = r_rd_valid;
    assign busy     = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_sp_param
//  Purpose  : Directed self-checking bench for ram_sp_param. Three instances
//             share one stimulus stream: 8-bit read-first, 8-bit write-first
//             and 16-bit read-first (8-bit instances see the low lane only).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_sp_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_req;
    logic        wr_en;
    logic [1:0]  be;
    logic        rd_en;
    logic [3:0]  addr;
    logic [15:0] din;

    logic [7:0]  dout0, dout1;
    logic [15:0] dout2;
    logic        rv0, rv1, rv2;
    logic        busy0, busy1, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0), .CLEAR_VAL(8'h5A)) u_rf8 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .be(be[0:0]),
        .rd_en(rd_en), .addr(addr), .din(din[7:0]), .dout(dout0), .rd_valid(rv0),
        .busy(busy0));

    ram_sp_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(1), .CLEAR_VAL(8'h5A)) u_wf8 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .be(be[0:0]),
        .rd_en(rd_en), .addr(addr), .din(din[7:0]), .dout(dout1), .rd_valid(rv1),
        .busy(busy1));

    ram_sp_param #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .CLEAR_VAL(16'hC3C3)) u_rf16 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .wr_en(wr_en), .be(be),
        .rd_en(rd_en), .addr(addr), .din(din), .dout(dout2), .rd_valid(rv2),
        .busy(busy2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs set before tick() apply to the next rising edge; outputs are
    // sampled 1 time unit after that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; be = 2'b00; addr = '0; din = '0;
    endtask

    // Counts edges until busy drops; also reports whether any rd_valid was
    // seen meanwhile. Bounded so a stuck sequencer ends as a failed check.
    task automatic wait_clear(output int n, output logic saw_valid, input logic poke);
        n = 0;
        saw_valid = 1'b0;
        while (busy0 && n < 40) begin
            if (poke) begin
                wr_en = 1'b1; rd_en = 1'b1; be = 2'b11; addr = 4'd0; din = 16'h9999;
            end
            tick();
            n++;
            saw_valid = saw_valid | rv0 | rv1 | rv2;
        end
        idle_inputs();
    endtask

    task automatic read(input logic [3:0] a);
        addr = a; rd_en = 1'b1; wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        addr = a; din = d; be = b; wr_en = 1'b1; rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_all_clear(input string tag);
        for (int a = 0; a < 16; a++) begin
            read(4'(a));
            check({tag, "_rf8"},  {24'h0, dout0}, 32'h5A);
            check({tag, "_wf8"},  {24'h0, dout1}, 32'h5A);
            check({tag, "_rf16"}, {16'h0, dout2}, 32'hC3C3);
            check({tag, "_rv"},   {29'h0, rv0, rv1, rv2}, 32'h7);
        end
    endtask

    initial begin
        int   n;
        logic sv;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_dout",  {dout2, dout1, dout0}, 32'h0);
        check("rst_valid", {29'h0, rv0, rv1, rv2}, 32'h0);
        check("rst_busy",  {29'h0, busy0, busy1, busy2}, 32'h7);
        rst_n = 1'b1;

        // ---------------- post-reset clear ----------------
        wait_clear(n, sv, 1'b0);
        check("init_busy_edges", n, 16);
        check("init_busy_all",   {29'h0, busy0, busy1, busy2}, 32'h0);
        check_all_clear("init_rd");
        tick();
        check("no_rd_valid", {29'h0, rv0, rv1, rv2}, 32'h0);
        check("dout_hold",   {8'h0, dout1, dout0}, 32'h5A5A);

        // ---------------- basic write/read ----------------
        write(4'd1, 16'h77AA, 2'b11);
        write(4'd2, 16'h8855, 2'b11);
        read(4'd1);
        check("rd1_rf8",  {24'h0, dout0}, 32'hAA);
        check("rd1_rf16", {16'h0, dout2}, 32'h77AA);
        check("rd1_valid", {31'h0, rv0}, 32'h1);
        read(4'd2);
        check("rd2_rf8",  {24'h0, dout0}, 32'h55);
        check("rd2_wf8",  {24'h0, dout1}, 32'h55);
        check("rd2_rf16", {16'h0, dout2}, 32'h8855);

        // ---------------- byte enables ----------------
        write(4'd3, 16'h1234, 2'b11);
        write(4'd3, 16'hABCD, 2'b01);
        read(4'd3);
        check("be01_rf16", {16'h0, dout2}, 32'h12CD);
        check("be01_rf8",  {24'h0, dout0}, 32'hCD);
        write(4'd3, 16'hEEFF, 2'b10);
        write(4'd3, 16'h0000, 2'b00);
        read(4'd3);
        check("be10_rf16", {16'h0, dout2}, 32'hEECD);
        check("be10_rf8",  {24'h0, dout0}, 32'hCD);

        // ---------------- read during write ----------------
        write(4'd5, 16'h1111, 2'b11);
        addr = 4'd5; din = 16'h2222; be = 2'b11; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw_rf8",  {24'h0, dout0}, 32'h11);
        check("rdw_wf8",  {24'h0, dout1}, 32'h22);
        check("rdw_rf16", {16'h0, dout2}, 32'h1111);
        read(4'd5);
        check("rdw_after_rf8",  {24'h0, dout0}, 32'h22);
        check("rdw_after_wf8",  {24'h0, dout1}, 32'h22);
        check("rdw_after_rf16", {16'h0, dout2}, 32'h2222);
        // write-first with a partial lane write returns the merged word
        addr = 4'd5; din = 16'h3333; be = 2'b10; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw_part_wf8",  {24'h0, dout1}, 32'h22);
        check("rdw_part_rf16", {16'h0, dout2}, 32'h2222);
        read(4'd5);
        check("rdw_part_after_rf16", {16'h0, dout2}, 32'h3322);

        // ---------------- clr_req with same-edge write ----------------
        addr = 4'd0; din = 16'h00FF; be = 2'b11; wr_en = 1'b1; clr_req = 1'b1;
        tick();
        idle_inputs();
        check("clr_busy", {29'h0, busy0, busy1, busy2}, 32'h7);
        wait_clear(n, sv, 1'b1);
        check("clr_busy_edges", n, 16);
        check("clr_no_valid", {31'h0, sv}, 32'h0);
        check("clr_dout_held", {16'h0, dout2}, 32'h3322);
        read(4'd0);
        check("clr_addr0_rf8",  {24'h0, dout0}, 32'h5A);
        check("clr_addr0_rf16", {16'h0, dout2}, 32'hC3C3);
        read(4'd1);
        check("clr_addr1_rf8",  {24'h0, dout0}, 32'h5A);

        // ---------------- reset mid-clear ----------------
        write(4'd10, 16'hBEEF, 2'b11);
        write(4'd12, 16'hCAFE, 2'b11);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();  // clear pointer now at 7
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout",  {dout2, dout1, dout0}, 32'h0);
        check("mid_rst_valid", {29'h0, rv0, rv1, rv2}, 32'h0);
        check("mid_rst_busy",  {29'h0, busy0, busy1, busy2}, 32'h7);
        tick();
        rst_n = 1'b1;
        wait_clear(n, sv, 1'b0);
        check("mid_rst_busy_edges", n, 16);
        check_all_clear("mid_rst_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed=running expected=done");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
